// File: rtl/mips_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface mips_fetch_stage_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned IW = 32
);
    logic          ImemReq;
    logic [AW-1:0] ImemAddr;
    logic [IW-1:0] ImemData;
    logic          ImemAck;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemData,
        input  ImemAck
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemData,
        output ImemAck
    );
endinterface

// File: rtl/mips_fetch_stage.sv
// Instruction fetch stage: PC, imem request, one-entry skid buffer and IF/ID register
// with redirect and flush handling from later pipeline stages.
module mips_fetch_stage #(
    parameter int unsigned   AW  = 32,
    parameter int unsigned   IW  = 32,
    parameter logic [IW-1:0] NOP = '0
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [AW-1:0]      startPC,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               RedirectValid,
    input  logic [AW-1:0]      RedirectPC,
    mips_fetch_stage_if.master imem,
    output logic [IW-1:0]      IF_ID_Instr,
    output logic [AW-1:0]      IF_ID_PCPlus4,
    output logic               IF_ID_Valid,
    output logic               Misalign
);

    typedef enum logic {
        FETCH,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] skid_instr_q, skid_instr_d;
    logic [AW-1:0] skid_pc4_q, skid_pc4_d;
    logic [IW-1:0] ifid_instr_q, ifid_instr_d;
    logic [AW-1:0] ifid_pc4_q, ifid_pc4_d;
    logic          ifid_valid_q, ifid_valid_d;
    logic          misalign_q, misalign_d;

    logic [AW-1:0] pc_plus4;
    logic          ack;

    assign pc_plus4      = pc_q + AW'(4);
    assign imem.ImemReq  = (state_q == FETCH) && !Reset;
    assign imem.ImemAddr = pc_q;
    assign ack           = imem.ImemAck && (state_q == FETCH);

    assign IF_ID_Instr   = ifid_instr_q;
    assign IF_ID_PCPlus4 = ifid_pc4_q;
    assign IF_ID_Valid   = ifid_valid_q;
    assign Misalign      = misalign_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        misalign_d   = 1'b0;

        if (RedirectValid) begin
            // Acked data is dropped; the skid contents die implicitly by leaving HOLD.
            pc_d       = {RedirectPC[AW-1:2], 2'b00};
            state_d    = FETCH;
            misalign_d = |RedirectPC[1:0];
            if (Flush) begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP;
            end
        end else if (Flush) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP;
            state_d      = FETCH;
            if (ack) begin
                pc_d = pc_plus4;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (ack) begin
                        pc_d = pc_plus4;
                        if (Stall) begin
                            skid_instr_d = imem.ImemData;
                            skid_pc4_d   = pc_plus4;
                            state_d      = HOLD;
                        end else begin
                            ifid_instr_d = imem.ImemData;
                            ifid_pc4_d   = pc_plus4;
                            ifid_valid_d = 1'b1;
                        end
                    end else if (!Stall) begin
                        ifid_valid_d = 1'b0;
                        ifid_instr_d = NOP;
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        ifid_instr_d = skid_instr_q;
                        ifid_pc4_d   = skid_pc4_q;
                        ifid_valid_d = 1'b1;
                        state_d      = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= FETCH;
            pc_q         <= startPC;
            skid_instr_q <= NOP;
            skid_pc4_q   <= '0;
            ifid_instr_q <= NOP;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            misalign_q   <= misalign_d;
        end
    end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Scoreboard bench for mips_fetch_stage: directed scenarios then random traffic,
// checked cycle by cycle against a reference model of the fetch rules.
module tb_mips_fetch_stage;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] startPC = 32'h0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        RedirectValid = 1'b0;
    logic [31:0] RedirectPC = 32'h0;
    logic        ack_rand = 1'b0;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        Misalign;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_fetch_stage_if #(.AW(32), .IW(32)) imem_bus ();

    mips_fetch_stage #(.AW(32), .IW(32), .NOP(32'h0)) dut (
        .CLK           (clk),
        .Reset         (Reset),
        .startPC       (startPC),
        .Stall         (Stall),
        .Flush         (Flush),
        .RedirectValid (RedirectValid),
        .RedirectPC    (RedirectPC),
        .imem          (imem_bus.master),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_PCPlus4 (IF_ID_PCPlus4),
        .IF_ID_Valid   (IF_ID_Valid),
        .Misalign      (Misalign)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h20) return 32'h8C010004;
        return ((a * 32'h9E3779B1) ^ 32'h5A5A0000) | 32'h1;
    endfunction

    // Memory responder: data follows the address, ack only answers a request.
    assign imem_bus.ImemData = mem_word(imem_bus.ImemAddr);
    assign imem_bus.ImemAck  = ack_rand && imem_bus.ImemReq;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } item_t;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
    } snap_t;

    // Reference model: the skid is simply a list of instructions waiting for decode.
    logic [31:0] m_pc;
    item_t       m_skid[$];
    item_t       m_ifid;
    logic        m_valid;
    logic        m_mis;
    bit          m_ok = 0;
    snap_t       exp_q[$];

    task automatic model_step();
        bit          fetching;
        bit          took;
        logic [31:0] word;
        logic [31:0] nxt;
        if (Reset) begin
            m_pc    = startPC;
            m_skid.delete();
            m_ifid  = '{instr: 32'h0, pc4: 32'h0};
            m_valid = 1'b0;
            m_mis   = 1'b0;
            m_ok    = 1;
            return;
        end
        if (!m_ok) return;
        m_mis    = 1'b0;
        fetching = (m_skid.size() == 0);
        took     = fetching && ack_rand;
        word     = mem_word(m_pc);
        nxt      = m_pc + 32'd4;
        if (RedirectValid) begin
            m_pc = {RedirectPC[31:2], 2'b00};
            m_skid.delete();
            m_mis = |RedirectPC[1:0];
            if (Flush) begin
                m_valid = 1'b0;
                m_ifid.instr = 32'h0;
            end
        end else if (Flush) begin
            m_valid = 1'b0;
            m_ifid.instr = 32'h0;
            m_skid.delete();
            if (took) m_pc = nxt;
        end else if (!fetching) begin
            if (!Stall) begin
                m_ifid  = m_skid.pop_front();
                m_valid = 1'b1;
            end
        end else if (took) begin
            m_pc = nxt;
            if (Stall) m_skid.push_back('{instr: word, pc4: nxt});
            else begin
                m_ifid  = '{instr: word, pc4: nxt};
                m_valid = 1'b1;
            end
        end else if (!Stall) begin
            m_valid = 1'b0;
            m_ifid.instr = 32'h0;
        end
    endtask

    task automatic cyc(input bit rst, input logic [31:0] spc, input bit st, input bit fl,
                       input bit rv, input logic [31:0] rpc, input bit ak);
        snap_t s;
        @(posedge clk);
        #1;
        model_step();
        Reset         = rst;
        startPC       = spc;
        Stall         = st;
        Flush         = fl;
        RedirectValid = rv;
        RedirectPC    = rpc;
        ack_rand      = ak;
        if (m_ok) begin
            s.req   = !rst && (m_skid.size() == 0);
            s.addr  = m_pc;
            s.instr = m_ifid.instr;
            s.pc4   = m_ifid.pc4;
            s.valid = m_valid;
            s.mis   = m_mis;
            exp_q.push_back(s);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        snap_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ImemReq",       {31'b0, imem_bus.ImemReq}, {31'b0, e.req});
            chk("ImemAddr",      imem_bus.ImemAddr,         e.addr);
            chk("IF_ID_Valid",   {31'b0, IF_ID_Valid},      {31'b0, e.valid});
            chk("IF_ID_Instr",   IF_ID_Instr,               e.instr);
            chk("IF_ID_PCPlus4", IF_ID_PCPlus4,             e.pc4);
            chk("Misalign",      {31'b0, Misalign},         {31'b0, e.mis});
        end
    end

    initial begin
        // Reset at 0x00400000 then back-to-back fetch
        cyc(1, 32'h0040_0000, 0, 0, 0, 0, 1);
        cyc(1, 32'h0040_0000, 0, 0, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 1);
        // Wait states at 0x10
        cyc(0, 0, 0, 0, 1, 32'h10, 1);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 1);
        // Stall against an ack at 0x20, held for 3 cycles
        cyc(0, 0, 0, 0, 1, 32'h20, 1);
        repeat (3) cyc(0, 0, 1, 0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
        // Misaligned redirect with flush on top of an ack
        cyc(0, 0, 0, 1, 1, 32'h103, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
        // Reset while holding a full skid buffer
        cyc(0, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 1);
        cyc(1, 32'h40, 1, 0, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 1);
        // PC wrap-around
        cyc(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                $urandom() & 32'hFFFF_FFFC,
                ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 11) == 0),
                $urandom(),
                ($urandom_range(0, 9) < 7));
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Parametrised instruction-fetch stage for the pipelined successor of the single-cycle processor.
- Owns the program counter and issues requests to an instruction memory that may insert wait states.
- Holds a one-entry skid buffer so a returned instruction is never lost while the decode stage stalls.
- Drives the IF/ID pipeline register and applies branch/jump redirects and flushes from later stages.

Parameters:
AW, 32, PC and address width in bits (minimum 8)
IW, 32, instruction width in bits
NOP, 0, value written to IF_ID_Instr on reset, flush or bubble

Ports:
CLK  in  1  clock; all state updates on the rising edge
Reset  in  1  synchronous, active-high reset
startPC  in  AW  PC value loaded while Reset is high
Stall  in  1  hazard unit: hold the IF/ID register
Flush  in  1  kill the IF/ID contents and the skid buffer
RedirectValid  in  1  branch/jump taken this cycle
RedirectPC  in  AW  redirect target
ImemReq  out  1  fetch request
ImemAddr  out  AW  fetch address, always equal to pc
ImemData  in  IW  instruction; valid only when ImemAck=1
ImemAck  in  1  same-cycle acknowledge of ImemReq
IF_ID_Instr  out  IW  registered instruction
IF_ID_PCPlus4  out  AW  registered pc+4 of that instruction
IF_ID_Valid  out  1  IF/ID register holds a live instruction
Misalign  out  1  registered one-cycle pulse: RedirectPC[1:0] was nonzero

Behaviour:
- Reset (synchronous, any state):
  - pc<=startPC, state<=FETCH, skid buffer empty.
  - IF_ID_Instr<=NOP, IF_ID_PCPlus4<=0, IF_ID_Valid<=0, Misalign<=0.
  - ImemReq is forced 0 combinationally while Reset=1.
- States: FETCH, HOLD.
  - ImemReq = (state==FETCH) & !Reset.
  - ImemAddr = pc.
- Arithmetic: pc+4 is computed modulo 2^AW; 0xFFFFFFFC wraps to 0x00000000.
- Priority, highest first: Reset > RedirectValid > Flush > ack/stall logic.
- FETCH state:
  - Ack=1, Stall=0: IF_ID<={ImemData, pc+4, 1}; pc<=pc+4; stay in FETCH.
  - Ack=1, Stall=1: skid<={ImemData, pc+4}; pc<=pc+4; IF_ID held; go to HOLD.
  - Ack=0, Stall=0: insert a bubble (IF_ID_Valid<=0, IF_ID_Instr<=NOP); pc held.
  - Ack=0, Stall=1: IF_ID and pc held.
- HOLD state:
  - ImemReq=0.
  - Stall=1: everything held.
  - Stall=0: IF_ID<={skid, 1}; go to FETCH. The next request is issued the following cycle, so the skid-to-IF_ID move adds exactly one cycle.
- RedirectValid=1:
  - pc<={RedirectPC[AW-1:2], 2'b00}; state<=FETCH; skid discarded.
  - Any ImemData acknowledged in the same cycle is discarded and pc does not advance by 4.
  - Misalign<=|RedirectPC[1:0] for one cycle.
  - IF_ID is held, or flushed if Flush=1 in the same cycle.
- Flush=1:
  - IF_ID_Valid<=0 and IF_ID_Instr<=NOP, even when Stall=1.
  - Skid discarded; state<=FETCH.
  - pc unchanged unless redirected. In FETCH, a same-cycle ack still advances pc, but the data is dropped.
- Latency: with no wait states and no stalls, one instruction per cycle. An instruction appears in IF_ID one cycle after its ack.
- Invariant: at most one un-consumed instruction is held in the skid buffer, and no instruction is duplicated or skipped across stall/ack interleavings.

Test Plan:
- Reset=1 with startPC=0x00400000, then release; ack tied to 1 -> ImemAddr sequence 0x400000, 0x400004, 0x400008; IF_ID_Valid=1 from the second cycle; IF_ID_PCPlus4=0x400004 then 0x400008.
- Ack low for 2 cycles at pc=0x10 -> 2 bubbles (Valid=0, Instr=0); pc stays 0x10; the instruction at 0x10 is delivered after ack.
- Stall=1 in the same cycle as an ack at pc=0x20 carrying data 0x8C010004; Stall held 3 cycles -> HOLD, ImemReq=0, pc=0x24; on release IF_ID_Instr=0x8C010004, PCPlus4=0x24, next request is 0x24.
- RedirectValid=1, RedirectPC=0x103, Flush=1 in the same cycle as an ack -> pc=0x100, Misalign pulses once, IF_ID_Valid=0, acked data dropped, next ImemAddr=0x100.
- startPC=0xFFFFFFFC with ack=1 -> next ImemAddr=0x00000000 and IF_ID_PCPlus4=0x00000000.
- Reset asserted while in HOLD with a full skid -> after release pc=startPC, IF_ID_Valid=0, and the stale skid instruction never appears.
